// File: rtl/mdu_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_exec_unit_if
// Description : Dispatch, flush and CDB-broadcast signals for the RV32M
//               multiply/divide execution unit. The master side is the
//               reservation station plus CDB arbiter; the slave side is the unit.
// Revision    : 1.0  initial release
// ============================================================================
interface mdu_exec_unit_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic             flush;
   logic             start_valid;
   logic             start_ready;
   logic [2:0]       aluop_i;
   logic [TAG_W-1:0] destination_i;
   logic [XLEN-1:0]  src1_i;
   logic [XLEN-1:0]  src2_i;
   logic             done_valid;
   logic             done_ready;
   logic [XLEN-1:0]  result_o;
   logic [TAG_W-1:0] destination_o;

   modport master (
      output flush, start_valid, aluop_i, destination_i, src1_i, src2_i, done_ready,
      input  start_ready, done_valid, result_o, destination_o
   );

   modport slave (
      input  flush, start_valid, aluop_i, destination_i, src1_i, src2_i, done_ready,
      output start_ready, done_valid, result_o, destination_o
   );
endinterface
`default_nettype wire

// File: rtl/mdu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : mdu_exec_unit
// Description : Iterative RV32M multiply/divide unit. One shift-add or
//               restoring-subtract step per cycle on operand magnitudes; the
//               result is held until the CDB grants it.
//               Optional macro MDU_FAST_MUL_EN: multiplies finish in the
//               accept cycle using a single-cycle 64-bit product.
// Revision    : 1.0  initial release
// ============================================================================
module mdu_exec_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  wire logic clk,
   input  wire logic reset,
   mdu_exec_unit_if.slave bus
);
   localparam int                c_CNT_W = $clog2(XLEN);
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]    c_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [c_CNT_W-1:0]    r_count;
   logic [2:0]            r_op;
   logic [TAG_W-1:0]      r_tag;
   logic [XLEN-1:0]       r_result;
   logic [2*XLEN-1:0]     r_prod;     // {remainder/high, quotient/low}
   logic [XLEN-1:0]       r_opb;      // multiplicand or divisor magnitude
   logic                  r_neg_q;    // negate product / quotient at the end
   logic                  r_neg_r;    // negate remainder at the end
   logic                  w_done_valid;

   // Accept-cycle decode
   logic [2:0]      w_op;
   logic            w_start_ready, w_accept;
   logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
   logic [XLEN-1:0] w_a_abs, w_b_abs;
   logic            w_div_zero, w_div_ovf, w_short;
   logic [XLEN-1:0] w_short_res;

   assign w_op          = bus.aluop_i;
   assign w_start_ready = (r_state == S_IDLE) & reset;
   assign w_accept      = bus.start_valid & w_start_ready & ~bus.flush;

   // Signed divides (DIV/REM) have funct3[0]=0; MULH signs both, MULHSU only rs1
   assign w_a_signed = w_op[2] ? ~w_op[0] : (w_op == 3'b001 || w_op == 3'b010);
   assign w_b_signed = w_op[2] ? ~w_op[0] : (w_op == 3'b001);
   assign w_a_neg    = w_a_signed & bus.src1_i[XLEN-1];
   assign w_b_neg    = w_b_signed & bus.src2_i[XLEN-1];
   assign w_a_abs    = w_a_neg ? -bus.src1_i : bus.src1_i;
   assign w_b_abs    = w_b_neg ? -bus.src2_i : bus.src2_i;

   assign w_div_zero = w_op[2] & (bus.src2_i == '0);
   assign w_div_ovf  = w_op[2] & ~w_op[0] & (bus.src1_i == c_MIN) & (bus.src2_i == '1);
   // Remainder ops have funct3[1]=1
   assign w_short_res = w_div_zero ? (w_op[1] ? bus.src1_i : '1)
                                   : (w_op[1] ? '0 : c_MIN);

`ifdef MDU_FAST_MUL_EN
   logic signed [2*XLEN-1:0] w_fa, w_fb, w_fast_full;
   logic [XLEN-1:0]          w_fast_res;
   assign w_fa        = {{XLEN{w_a_neg}}, bus.src1_i};
   assign w_fb        = {{XLEN{w_b_neg}}, bus.src2_i};
   assign w_fast_full = w_fa * w_fb;
   assign w_fast_res  = (w_op == 3'b000) ? w_fast_full[XLEN-1:0] : w_fast_full[2*XLEN-1:XLEN];
   assign w_short     = w_div_zero | w_div_ovf | ~w_op[2];
`else
   assign w_short     = w_div_zero | w_div_ovf;
`endif

   // Iteration step
   logic [XLEN:0]     w_sum, w_shrem;
   logic [XLEN-1:0]   w_diff;
   logic              w_ge;
   logic [2*XLEN-1:0] w_mul_next, w_div_next, w_prod_next, w_prod_signed;
   logic [XLEN-1:0]   w_quo, w_rem;
   logic [XLEN-1:0]   w_final;

   assign w_sum      = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, (r_prod[0] ? r_opb : '0)};
   assign w_mul_next = {w_sum, r_prod[XLEN-1:1]};
   assign w_shrem    = r_prod[2*XLEN-1:XLEN-1];
   assign w_ge       = (w_shrem >= {1'b0, r_opb});
   assign w_diff     = w_shrem[XLEN-1:0] - r_opb;
   assign w_div_next = w_ge ? {w_diff,             r_prod[XLEN-2:0], 1'b1}
                            : {w_shrem[XLEN-1:0],  r_prod[XLEN-2:0], 1'b0};
   assign w_prod_next   = r_op[2] ? w_div_next : w_mul_next;
   // MUL never sets r_neg_q, so its low half can come from the signed product too
   assign w_prod_signed = r_neg_q ? -w_prod_next : w_prod_next;
   assign w_quo = r_neg_q ? -w_prod_next[XLEN-1:0] : w_prod_next[XLEN-1:0];
   assign w_rem = r_neg_r ? -w_prod_next[2*XLEN-1:XLEN] : w_prod_next[2*XLEN-1:XLEN];

   // Pick the architectural result from the final iteration value
   always_comb begin
      w_final = '0;
      case (r_op)
         3'b000:                 w_final = w_prod_signed[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_final = w_prod_signed[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_final = w_quo;
         default:                w_final = w_rem;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state and handshake outputs; flush overrides accept and grant
   always_comb begin
      w_state_next = r_state;
      w_done_valid = 1'b0;
      case (r_state)
         S_IDLE: if (w_accept) w_state_next = w_short ? S_DONE : S_CALC;
         S_CALC: if (r_count == c_LAST) w_state_next = S_DONE;
         S_DONE: begin
            w_done_valid = 1'b1;
            if (bus.done_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
      if (bus.flush) w_state_next = S_IDLE;
   end

   // Operand capture, iteration datapath and result register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count  <= '0;
         r_op     <= '0;
         r_tag    <= '0;
         r_result <= '0;
         r_prod   <= '0;
         r_opb    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
      end else if (r_state == S_IDLE) begin
         if (w_accept) begin
            r_count <= '0;
            r_op    <= w_op;
            r_tag   <= bus.destination_i;
            r_prod  <= {{XLEN{1'b0}}, w_a_abs};
            r_opb   <= w_b_abs;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (w_div_zero | w_div_ovf) r_result <= w_short_res;
`ifdef MDU_FAST_MUL_EN
            else if (!w_op[2])          r_result <= w_fast_res;
`endif
         end
      end else if (r_state == S_CALC) begin
         r_prod  <= w_prod_next;
         r_count <= r_count + c_CNT_W'(1);
         if (r_count == c_LAST) begin
            r_result <= w_final;
            r_count  <= '0;
         end
      end
   end

   assign bus.start_ready   = w_start_ready;
   assign bus.done_valid    = w_done_valid;
   assign bus.result_o      = r_result;
   assign bus.destination_o = r_tag;
endmodule
`default_nettype wire

// File: tb/tb_mdu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_exec_unit
// Description : Self-checking bench for mdu_exec_unit: directed vectors,
//               handshake/flush/reset sequences and random operations
//               against an arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mdu_exec_unit;
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mdu_exec_unit_if #(.XLEN(32), .TAG_W(5)) bus ();
   mdu_exec_unit #(.XLEN(32), .TAG_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  tag;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain 64-bit arithmetic plus the RV32M special cases
   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      case (op)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
      if (op[2] && b == 0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MDU_FAST_MUL_EN
      if (!op[2]) return 1;
`endif
      return 33;
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
      int n = 0;
      while (!bus.start_ready && n < 100) begin tick(); n++; end
      if (n >= 100) check("ready_timeout", {31'd0, bus.start_ready}, 32'd1);
      bus.start_valid   = 1'b1;
      bus.aluop_i       = op;
      bus.src1_i        = a;
      bus.src2_i        = b;
      bus.destination_i = tag;
      tick();
      bus.start_valid   = 1'b0;
      bus.aluop_i       = 3'($urandom);
      bus.src1_i        = $urandom;
      bus.src2_i        = $urandom;
      bus.destination_i = 5'($urandom);
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (!bus.done_valid && lat < 200) begin tick(); lat++; end
   endtask

   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
      int lat;
      issue(op, a, b, tag);
      wait_done(lat);
      check({name, "_lat"}, lat, ref_latency(op, a, b));
      check({name, "_res"}, bus.result_o, exp);
      check({name, "_tag"}, {27'd0, bus.destination_o}, {27'd0, tag});
      tick();  // grant edge (done_ready held high)
      check({name, "_dv_drop"}, {31'd0, bus.done_valid}, 32'd0);
      check({name, "_rdy"}, {31'd0, bus.start_ready}, 32'd1);
   endtask

   task automatic watch_no_done(input string name);
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.done_valid) seen++;
      end
      check(name, seen, 0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
      vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000};
      vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
      vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF};
      vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD};
      vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF};
      vecs[6]  = '{3'd5, 32'd100,        32'd7,         5'd7,  32'd14};
      vecs[7]  = '{3'd7, 32'd100,        32'd7,         5'd8,  32'd2};
      vecs[8]  = '{3'd5, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF};
      vecs[9]  = '{3'd6, 32'd5,          32'd0,         5'd10, 32'd5};
      vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000};
      vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0};
      vecs[12] = '{3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd31, 32'd1};

      bus.flush = 1'b0; bus.start_valid = 1'b0; bus.done_ready = 1'b1;
      bus.aluop_i = '0; bus.src1_i = '0; bus.src2_i = '0; bus.destination_i = '0;

      // Reset state
      repeat (3) tick();
      check("rst_ready", {31'd0, bus.start_ready}, 32'd0);
      check("rst_dv",    {31'd0, bus.done_valid},  32'd0);
      check("rst_res",   bus.result_o, 32'd0);
      check("rst_tag",   {27'd0, bus.destination_o}, 32'd0);
      reset = 1'b1;
      tick();
      check("idle_ready", {31'd0, bus.start_ready}, 32'd1);

      // Directed vectors
      for (int i = 0; i < 13; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp);

      // Hold result while grant is withheld
      begin
         int lat;
         bus.done_ready = 1'b0;
         issue(3'd5, 32'd100, 32'd7, 5'd9);
         wait_done(lat);
         check("hold_lat", lat, 33);
         for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_res", bus.result_o, 32'd14);
            check("hold_tag", {27'd0, bus.destination_o}, 32'd9);
            check("hold_dv",  {31'd0, bus.done_valid}, 32'd1);
            check("hold_rdy", {31'd0, bus.start_ready}, 32'd0);
         end
         bus.done_ready = 1'b1;
         tick();
         check("grant_dv",  {31'd0, bus.done_valid}, 32'd0);
         check("grant_rdy", {31'd0, bus.start_ready}, 32'd1);
      end

      // Flush at CALC step 12
      issue(3'd5, 32'hFFFF_FFFF, 32'd3, 5'd3);
      repeat (12) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("flush_dv",  {31'd0, bus.done_valid}, 32'd0);
      check("flush_rdy", {31'd0, bus.start_ready}, 32'd1);
      watch_no_done("flush_no_done");

      // Flush in DONE drops the held result
      begin
         int lat;
         bus.done_ready = 1'b0;
         issue(3'd5, 32'd5, 32'd0, 5'd4);
         wait_done(lat);
         check("fdone_lat", lat, 1);
         bus.flush = 1'b1;
         tick();
         bus.flush = 1'b0;
         check("fdone_dv",  {31'd0, bus.done_valid}, 32'd0);
         check("fdone_rdy", {31'd0, bus.start_ready}, 32'd1);
         bus.done_ready = 1'b1;
      end

      // Flush together with start_valid: not accepted
      bus.start_valid = 1'b1; bus.flush = 1'b1;
      bus.aluop_i = 3'd5; bus.src1_i = 32'd50; bus.src2_i = 32'd5; bus.destination_i = 5'd2;
      tick();
      bus.start_valid = 1'b0; bus.flush = 1'b0;
      check("fstart_rdy", {31'd0, bus.start_ready}, 32'd1);
      watch_no_done("fstart_no_done");

      // Reset in the middle of CALC
      run_op("pre_rst", 3'd5, 32'd100, 32'd7, 5'd9, 32'd14);
      issue(3'd5, 32'd1000, 32'd3, 5'd7);
      repeat (10) tick();
      reset = 1'b0;
      tick();
      check("mrst_rdy", {31'd0, bus.start_ready}, 32'd0);
      check("mrst_dv",  {31'd0, bus.done_valid}, 32'd0);
      check("mrst_res", bus.result_o, 32'd0);
      check("mrst_tag", {27'd0, bus.destination_o}, 32'd0);
      reset = 1'b1;
      tick();
      check("mrst_rdy_after", {31'd0, bus.start_ready}, 32'd1);
      watch_no_done("mrst_no_done");

      // Random operations against the reference model
      for (int i = 0; i < 200; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         logic [4:0]  tag;
         op  = 3'($urandom_range(0, 7));
         a   = pick();
         b   = pick();
         tag = 5'($urandom);
         run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, tag, ref_result(op, a, b));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mdu_exec_unit.md
Name: mdu_exec_unit

Overview:
- Iterative RV32M multiply/divide execution unit. Sits directly downstream of the multiply reservation station.
- Accepts one dispatched operation: funct3, destination tag and both resolved operands.
- Computes the result over multiple cycles and holds it until the common-data-bus (CDB) arbiter grants a broadcast.
- Handles one operation at a time. Busy while computing or while holding an ungranted result.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.
- TAG_W, 5, width of the destination tag.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  synchronous abort of any in-flight or held operation.
- start_valid  in  1  the reservation station presents a ready operation.
- start_ready  out  1  unit can accept (high only in IDLE).
- aluop_i  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- destination_i  in  TAG_W  destination tag.
- src1_i  in  XLEN  rs1 operand.
- src2_i  in  XLEN  rs2 operand.
- done_valid  out  1  result available for CDB broadcast.
- done_ready  in  1  CDB grant.
- result_o  out  XLEN  result value.
- destination_o  out  TAG_W  tag of the result.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on posedge clk.
  - reset low at a posedge: state goes to IDLE; done_valid=0, result_o=0, destination_o=0, iteration counter=0.
  - start_ready=0 while reset is low. Reset mid-operation discards the operation.
- States:
  - IDLE: start_ready=1.
  - CALC: performs iterations.
  - DONE: done_valid=1.
- Accept:
  - Handshake is start_valid & start_ready in IDLE.
  - On accept, latch aluop, tag and operands.
  - Normally go to CALC with count=0.
  - Special cases go straight to DONE with the result already registered (latency 1):
    - Any div/rem op with src2==0.
    - DIV/REM with src1=0x80000000 and src2=0xFFFFFFFF.
- CALC:
  - One shift-add (multiply) or restoring-subtract (divide) step per cycle, on operand magnitudes.
  - Signed ops take absolute values at accept and fix the sign when entering DONE.
    - MULH: both operands signed.
    - MULHSU: src1 signed, src2 unsigned.
    - DIV/REM: quotient sign = sign(src1) xor sign(src2); remainder sign = sign(src1).
  - After XLEN steps (count==XLEN-1), transition to DONE.
  - done_valid first rises XLEN+1 cycles after the accept cycle.
- Results:
  - MUL: low 32 bits of the 64-bit product.
  - MULH, MULHSU, MULHU: high 32 bits.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Divide by zero: quotient = 0xFFFFFFFF for both signed and unsigned; remainder = src1.
  - Signed overflow: quotient = 0x80000000; remainder = 0.
- DONE:
  - result_o and destination_o are stable while done_valid=1 and done_ready=0.
  - On done_valid & done_ready, go to IDLE; done_valid is low the next cycle.
  - A new op cannot be accepted in the same cycle as the grant; minimum issue interval is XLEN+2 cycles.
- Flush:
  - Asserted in any state: next state is IDLE and done_valid=0 the next cycle; the operation is dropped.
  - Flush has priority over a same-cycle accept and over a same-cycle grant. The result is not counted as broadcast.
  - Flush and reset together: reset wins; the effect is identical.
- Inputs aluop_i, destination_i, src1_i and src2_i are ignored outside the accept cycle.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: MUL, MULH, MULHSU and MULHU compute a full 64-bit product in the accept cycle. They go directly to DONE, so done_valid is high the cycle after accept. Div/rem ops remain iterative.
- Undefined: all multiplies take the iterative XLEN-step path described above.

Test Plan:
- MUL, src1=7, src2=-3 (0xFFFFFFFD), tag 5, done_ready=1 -> result 0xFFFFFFEB with tag 5; done_valid rises 33 cycles after accept (1 cycle with MDU_FAST_MUL_EN).
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD. REM -7 / 2 -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, each with done_valid 1 cycle after accept. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Hold done_ready=0 for 10 cycles in DONE -> result_o and destination_o unchanged and start_ready=0; grant -> start_ready=1 the next cycle.
- Flush at CALC step 12 -> IDLE next cycle, no done_valid pulse; reset low mid-CALC -> all outputs 0; flush asserted together with start_valid in IDLE -> operation not accepted.
